writeback_arbiter: RTL and testbench

Writeback stage directly upstream of the register file write port. It merges two result streams into the single file write port: the ALU stream, which cannot be stalled, and the load/store stream, which uses a valid/ready handshake. Load results are buffered in a small FIFO and drained in idle ALU cycles. The block also kills stale load results and exposes a hazard query to issue logic.

---
 rtl/writeback_arbiter.sv | 105 ++++++++++
 tb/tb_writeback_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges the unstallable ALU stream with buffered
// load results, kills stale loads and answers issue-stage hazard queries.
module writeback_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid_in,
   input  logic [ADDR_WIDTH-1:0] alu_addr_in,
   input  logic [DATA_WIDTH-1:0] alu_data_in,
   input  logic                  lsu_valid_in,
   output logic                  lsu_ready_out,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
   input  logic [DATA_WIDTH-1:0] lsu_data_in,
   output logic                  write_out,
   output logic [ADDR_WIDTH-1:0] write_addr_out,
   output logic [DATA_WIDTH-1:0] write_data_out,
   input  logic [ADDR_WIDTH-1:0] hazard_addr_in,
   output logic                  hazard_out,
   output logic [15:0]           lsu_wait_count_out,
   input  logic                  debugen_in
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] kill;
   logic [FIFO_DEPTH-1:0] occupied;
   logic [PW-1:0]         rd_ptr, wr_ptr, off;
   logic [CW-1:0]         count;
   logic                  alu_live, head_valid, head_live, push, pop;

   // Write tracing is left to an external simulation monitor; the enable has no logic role.
   logic debug_unused;
   assign debug_unused = debugen_in;

   assign lsu_ready_out = reset && (count != CW'(FIFO_DEPTH));

   always_comb begin
      alu_live   = alu_valid_in && (alu_addr_in != '0);
      head_valid = (count != '0);
      head_live  = head_valid && !kill[rd_ptr];
      // A killed head drains even under an ALU write; a live one waits for an idle slot.
      pop        = head_valid && (kill[rd_ptr] || !alu_live);
      push       = lsu_valid_in && lsu_ready_out && (lsu_addr_in != '0);
   end

   always_comb begin
      off      = '0;
      occupied = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         off         = PW'(i) - rd_ptr;
         occupied[i] = ({1'b0, off} < count);
      end
   end

   always_comb begin
      hazard_out = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (occupied[i] && !kill[i] && (fifo_addr[i] == hazard_addr_in)) hazard_out = 1'b1;
      if (write_out && (write_addr_out == hazard_addr_in)) hazard_out = 1'b1;
      if (hazard_addr_in == '0) hazard_out = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= lsu_addr_in;
         fifo_data[wr_ptr] <= lsu_data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr             <= '0;
         wr_ptr             <= '0;
         count              <= '0;
         kill               <= '0;
         write_out          <= 1'b0;
         write_addr_out     <= '0;
         write_data_out     <= '0;
         lsu_wait_count_out <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         for (int i = 0; i < FIFO_DEPTH; i++)
            if (alu_live && (fifo_addr[i] == alu_addr_in)) kill[i] <= 1'b1;
         // The entry arriving this cycle is younger than the ALU result and must survive.
         if (push) kill[wr_ptr] <= 1'b0;
         write_out <= alu_live || head_live;
         if (alu_live) begin
            write_addr_out <= alu_addr_in;
            write_data_out <= alu_data_in;
         end else if (head_live) begin
            write_addr_out <= fifo_addr[rd_ptr];
            write_data_out <= fifo_data[rd_ptr];
         end
         if (lsu_valid_in && !lsu_ready_out && (lsu_wait_count_out != 16'hFFFF))
            lsu_wait_count_out <= lsu_wait_count_out + 16'd1;
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, reset corner case, then random
// traffic against a queue-based reference model.
module tb_writeback_arbiter;
   localparam int AW = 8, DW = 32, D = 4;

   logic          clk = 1'b0, reset;
   logic          alu_valid, lsu_valid, lsu_ready, write_en, hazard, debugen;
   logic [AW-1:0] alu_addr, lsu_addr, write_addr, hazard_addr;
   logic [DW-1:0] alu_data, lsu_data, write_data;
   logic [15:0]   wait_count;

   int errors = 0, checks = 0;

   writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .alu_valid_in(alu_valid), .alu_addr_in(alu_addr), .alu_data_in(alu_data),
      .lsu_valid_in(lsu_valid), .lsu_ready_out(lsu_ready),
      .lsu_addr_in(lsu_addr), .lsu_data_in(lsu_data),
      .write_out(write_en), .write_addr_out(write_addr), .write_data_out(write_data),
      .hazard_addr_in(hazard_addr), .hazard_out(hazard),
      .lsu_wait_count_out(wait_count), .debugen_in(debugen));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
      logic lv; logic [AW-1:0] la; logic [DW-1:0] ld;
      logic [AW-1:0] ha;
      logic ew; logic [AW-1:0] ea; logic [DW-1:0] ed;
      logic er; logic eh; logic [15:0] ewait;
   } vec_t;

   function automatic vec_t v(bit av, int aa, int ad, bit lv, int la, int ld, int ha,
                              bit ew, int ea, int ed, bit er, bit eh, int ewt);
      vec_t r;
      r.av = av; r.aa = AW'(aa); r.ad = DW'(ad);
      r.lv = lv; r.la = AW'(la); r.ld = DW'(ld); r.ha = AW'(ha);
      r.ew = ew; r.ea = AW'(ea); r.ed = DW'(ed);
      r.er = er; r.eh = eh; r.ewait = 16'(ewt);
      return r;
   endfunction

   // Reference model: a queue of buffered loads plus the registered write port.
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; bit k; } ent_t;
   ent_t          q[$];
   bit            m_w;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_d;
   logic [15:0]   m_wait;

   function automatic bit model_hz(logic [AW-1:0] ha);
      if (ha == 0) return 1'b0;
      foreach (q[i]) if (!q[i].k && q[i].a == ha) return 1'b1;
      return m_w && (m_a == ha);
   endfunction

   task automatic model_step();
      ent_t h;
      bit rdy  = (q.size() != D);
      bit live = alu_valid && (alu_addr != 0);
      m_w = 1'b0;
      if (live) begin m_w = 1'b1; m_a = alu_addr; m_d = alu_data; end
      if (q.size() > 0 && (q[0].k || !live)) begin
         h = q.pop_front();
         if (!h.k && !live) begin m_w = 1'b1; m_a = h.a; m_d = h.d; end
      end
      if (live) foreach (q[i]) if (q[i].a == alu_addr) q[i].k = 1'b1;
      if (lsu_valid && !rdy && m_wait != 16'hFFFF) m_wait++;
      if (lsu_valid && rdy && lsu_addr != 0) q.push_back('{lsu_addr, lsu_data, 1'b0});
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      lsu_valid = 0; lsu_addr = 0; lsu_data = 0; hazard_addr = 0;
   endtask

   vec_t tbl[30];

   initial begin
      tbl[0]  = v(1, 5,'h11, 0, 0,0,     0, 1, 5,'h11, 1,0,0);
      tbl[1]  = v(1, 0,'h22, 0, 0,0,     0, 0, 5,'h11, 1,0,0);
      tbl[2]  = v(1, 6,'h33, 1, 1,'h101, 1, 1, 6,'h33, 1,1,0);
      tbl[3]  = v(1, 7,'h44, 1, 2,'h102, 6, 1, 7,'h44, 1,0,0);
      tbl[4]  = v(1, 8,'h55, 1, 3,'h103, 0, 1, 8,'h55, 1,0,0);
      tbl[5]  = v(1,10,'h66, 1, 4,'h104, 4, 1,10,'h66, 0,1,0);
      tbl[6]  = v(1,11,'h77, 1, 5,'h105, 4, 1,11,'h77, 0,1,1);
      tbl[7]  = v(0, 0,0,    0, 0,0,     1, 1, 1,'h101, 1,1,1);
      tbl[8]  = v(0, 0,0,    0, 0,0,     1, 1, 2,'h102, 1,0,1);
      tbl[9]  = v(0, 0,0,    0, 0,0,     0, 1, 3,'h103, 1,0,1);
      tbl[10] = v(0, 0,0,    0, 0,0,     0, 1, 4,'h104, 1,0,1);
      tbl[11] = v(0, 0,0,    0, 0,0,     0, 0, 4,'h104, 1,0,1);
      tbl[12] = v(0, 0,0,    1, 7,'hAA,  7, 0, 4,'h104, 1,1,1);
      tbl[13] = v(1, 7,'hBB, 0, 0,0,     7, 1, 7,'hBB,  1,1,1);
      tbl[14] = v(0, 0,0,    0, 0,0,     7, 0, 7,'hBB,  1,0,1);
      tbl[15] = v(1, 9,'h01, 1, 9,'h02,  9, 1, 9,'h01,  1,1,1);
      tbl[16] = v(0, 0,0,    0, 0,0,     9, 1, 9,'h02,  1,1,1);
      tbl[17] = v(0, 0,0,    0, 0,0,     9, 0, 9,'h02,  1,0,1);
      tbl[18] = v(0, 0,0,    1, 3,'h333, 3, 0, 9,'h02,  1,1,1);
      tbl[19] = v(0, 0,0,    0, 0,0,     3, 1, 3,'h333, 1,1,1);
      tbl[20] = v(0, 0,0,    0, 0,0,     3, 0, 3,'h333, 1,0,1);
      tbl[21] = v(0, 0,0,    1,12,'hC,   0, 0, 3,'h333, 1,0,1);
      tbl[22] = v(0, 0,0,    0, 0,0,     0, 1,12,'hC,   1,0,1);
      tbl[23] = v(0, 0,0,    1, 0,'hDEAD,0, 0,12,'hC,   1,0,1);
      tbl[24] = v(0, 0,0,    0, 0,0,     0, 0,12,'hC,   1,0,1);
      tbl[25] = v(1,20,'h1,  1,13,'hD,   0, 1,20,'h1,   1,0,1);
      tbl[26] = v(1,13,'h2,  1,14,'hE,   0, 1,13,'h2,   1,0,1);
      tbl[27] = v(1,21,'h3,  0, 0,0,     0, 1,21,'h3,   1,0,1);
      tbl[28] = v(0, 0,0,    0, 0,0,    14, 1,14,'hE,   1,1,1);
      tbl[29] = v(0, 0,0,    0, 0,0,    14, 0,14,'hE,   1,0,1);

      debugen = 1'b0;
      idle_inputs();
      reset = 1'b0;
      lsu_valid = 1'b1; lsu_addr = 8'd2; lsu_data = 32'h5;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(lsu_ready), 0);
      check("rst_write", 32'(write_en), 0);
      check("rst_addr", 32'(write_addr), 0);
      check("rst_data", write_data, 0);
      check("rst_wait", 32'(wait_count), 0);
      lsu_valid = 1'b0;
      #1 reset = 1'b1;
      #1 check("release_ready", 32'(lsu_ready), 1);
      @(posedge clk); #1;

      foreach (tbl[r]) begin
         alu_valid = tbl[r].av; alu_addr = tbl[r].aa; alu_data = tbl[r].ad;
         lsu_valid = tbl[r].lv; lsu_addr = tbl[r].la; lsu_data = tbl[r].ld;
         hazard_addr = tbl[r].ha;
         @(posedge clk); #1;
         check($sformatf("row%0d_write", r), 32'(write_en), 32'(tbl[r].ew));
         check($sformatf("row%0d_addr", r), 32'(write_addr), 32'(tbl[r].ea));
         check($sformatf("row%0d_data", r), write_data, tbl[r].ed);
         check($sformatf("row%0d_ready", r), 32'(lsu_ready), 32'(tbl[r].er));
         check($sformatf("row%0d_hazard", r), 32'(hazard), 32'(tbl[r].eh));
         check($sformatf("row%0d_wait", r), 32'(wait_count), 32'(tbl[r].ewait));
      end

      // Mid-operation reset: buffered loads vanish without being written.
      alu_valid = 1; alu_addr = 30; alu_data = 1; lsu_valid = 1; lsu_addr = 1; lsu_data = 'h91;
      @(posedge clk); #1;
      alu_addr = 31; lsu_addr = 2; lsu_data = 'h92;
      @(posedge clk); #1;
      idle_inputs();
      hazard_addr = 1;
      #1 check("mid_hazard_before", 32'(hazard), 1);
      reset = 1'b0;
      #1;
      check("mid_rst_write", 32'(write_en), 0);
      check("mid_rst_ready", 32'(lsu_ready), 0);
      check("mid_rst_hazard", 32'(hazard), 0);
      @(posedge clk); #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("post_rst%0d_write", i), 32'(write_en), 0);
         check($sformatf("post_rst%0d_ready", i), 32'(lsu_ready), 1);
         check($sformatf("post_rst%0d_hazard", i), 32'(hazard), 0);
      end

      // Random traffic against the model; model starts from the reset state.
      q.delete(); m_w = 0; m_a = 0; m_d = 0; m_wait = 0;
      for (int i = 0; i < 400; i++) begin
         int alu_pct;
         alu_pct     = (i < 200) ? 70 : 30;
         alu_valid   = ($urandom_range(0, 99) < alu_pct);
         alu_addr    = AW'($urandom_range(0, 7));
         alu_data    = $urandom;
         lsu_valid   = ($urandom_range(0, 99) < 60);
         lsu_addr    = AW'($urandom_range(0, 7));
         lsu_data    = $urandom;
         hazard_addr = AW'($urandom_range(0, 7));
         #1;
         check("rnd_ready", 32'(lsu_ready), 32'(q.size() != D));
         check("rnd_hazard", 32'(hazard), 32'(model_hz(hazard_addr)));
         @(posedge clk);
         model_step();
         #1;
         check("rnd_write", 32'(write_en), 32'(m_w));
         check("rnd_addr", 32'(write_addr), 32'(m_a));
         check("rnd_data", write_data, m_d);
         check("rnd_wait", 32'(wait_count), 32'(m_wait));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
